bisr_spare_allocator: RTL and testbench

Sequential spare-allocation engine for the BISR weight-proxy repair path. On a start pulse it captures the BIST fault map of the PE array and the health map of the spare PEs. It then emits one remap pair (faulty PE → healthy spare) per handshake, using a parametrised priority first-zero search, and finishes with a done or fail pulse. It sits between the BIST result registers and the remap table that steers weights to spares.

---
 rtl/bisr_pkg.sv | 25 ++
 rtl/first_zero_finder.sv | 50 +++++
 rtl/bisr_spare_allocator.sv | 124 ++++++++++++
 tb/tb_bisr_spare_allocator.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/bisr_pkg.sv
// ============================================================================
// Module  : bisr_pkg
// Purpose : Shared state encoding and index-width helper for BISR spare allocation
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bisr_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SCAN = 3'd1,
    EMIT = 3'd2,
    DONE = 3'd3,
    FAIL = 3'd4
  } alloc_state_t;

  // An index into a 1-entry vector still needs one bit of storage.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/first_zero_finder.sv
// ============================================================================
// Module  : first_zero_finder
// Purpose : Combinational priority search for the first clear bit of a vector
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module first_zero_finder
  import bisr_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter bit PRIORITY_MSB = 1'b0,
  localparam int IDX_W       = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // The last matching bit visited overwrites earlier ones, so the scan
  // runs towards the winning end instead of stopping early.
  generate
    if (PRIORITY_MSB) begin : g_msb
      always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
          if (!vec[i]) begin
            idx   = IDX_W'(i);
            found = 1'b1;
          end
        end
      end
    end else begin : g_lsb
      always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
          if (!vec[i]) begin
            idx   = IDX_W'(i);
            found = 1'b1;
          end
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/bisr_spare_allocator.sv
// ============================================================================
// Module  : bisr_spare_allocator
// Purpose : Pairs each faulty PE with a healthy spare, one pair per handshake
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bisr_spare_allocator
  import bisr_pkg::*;
#(
  parameter int NUM_PES      = 16,
  parameter int NUM_SPARES   = 4,
  parameter bit PRIORITY_MSB = 1'b0,
  localparam int PE_W        = idx_w(NUM_PES),
  localparam int SP_W        = idx_w(NUM_SPARES),
  localparam int CNT_W       = $clog2(NUM_SPARES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NUM_PES-1:0]    fault_map,
  input  logic [NUM_SPARES-1:0] spare_fault,
  output logic                  map_valid,
  input  logic                  map_ready,
  output logic [PE_W-1:0]       map_pe,
  output logic [SP_W-1:0]       map_spare,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [CNT_W-1:0]      spares_used
);

  alloc_state_t          r_state;
  logic [NUM_PES-1:0]    r_pend;
  logic [NUM_SPARES-1:0] r_used;

  logic [PE_W-1:0]       w_pe_idx;
  logic                  w_pe_found;
  logic [SP_W-1:0]       w_sp_idx;
  logic                  w_sp_found;

  // Searching the inverted pending map turns first-zero into first-faulty.
  first_zero_finder #(
    .WIDTH        (NUM_PES),
    .PRIORITY_MSB (PRIORITY_MSB)
  ) u_pe_find (
    .vec   (~r_pend),
    .idx   (w_pe_idx),
    .found (w_pe_found)
  );

  first_zero_finder #(
    .WIDTH        (NUM_SPARES),
    .PRIORITY_MSB (PRIORITY_MSB)
  ) u_sp_find (
    .vec   (r_used),
    .idx   (w_sp_idx),
    .found (w_sp_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_pend      <= '0;
      r_used      <= '0;
      map_valid   <= 1'b0;
      map_pe      <= '0;
      map_spare   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
      spares_used <= '0;
    end else begin
      done <= 1'b0;
      fail <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_pend      <= fault_map;
            r_used      <= spare_fault;
            spares_used <= '0;
            busy        <= 1'b1;
            r_state     <= SCAN;
          end
        end
        SCAN: begin
          if (!w_pe_found) begin
            done    <= 1'b1;
            r_state <= DONE;
          end else if (!w_sp_found) begin
            fail    <= 1'b1;
            r_state <= FAIL;
          end else begin
            map_pe    <= w_pe_idx;
            map_spare <= w_sp_idx;
            map_valid <= 1'b1;
            r_state   <= EMIT;
          end
        end
        EMIT: begin
          if (map_ready) begin
            map_valid         <= 1'b0;
            r_pend[map_pe]    <= 1'b0;
            r_used[map_spare] <= 1'b1;
            spares_used       <= spares_used + CNT_W'(1);
            r_state           <= SCAN;
          end
        end
        DONE, FAIL: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          busy      <= 1'b0;
          map_valid <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bisr_spare_allocator.sv
// ============================================================================
// Module  : tb_bisr_spare_allocator
// Purpose : Self-checking bench for LSB- and MSB-priority allocator instances
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bisr_spare_allocator;

  logic       clk;
  logic       rst_n;
  logic       start_s     [2];
  logic [15:0] fm_s       [2];
  logic [3:0] sf_s        [2];
  logic       ready_s     [2];
  logic       valid_o     [2];
  logic [3:0] pe_o        [2];
  logic [1:0] sp_o        [2];
  logic       busy_o      [2];
  logic       done_o      [2];
  logic       fail_o      [2];
  logic [2:0] used_o      [2];

  int tests = 0;
  int fails = 0;

  bisr_spare_allocator #(.NUM_PES(16), .NUM_SPARES(4), .PRIORITY_MSB(1'b0)) u_dut_lsb (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .fault_map(fm_s[0]),
    .spare_fault(sf_s[0]), .map_valid(valid_o[0]), .map_ready(ready_s[0]),
    .map_pe(pe_o[0]), .map_spare(sp_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .fail(fail_o[0]), .spares_used(used_o[0])
  );

  bisr_spare_allocator #(.NUM_PES(16), .NUM_SPARES(4), .PRIORITY_MSB(1'b1)) u_dut_msb (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .fault_map(fm_s[1]),
    .spare_fault(sf_s[1]), .map_valid(valid_o[1]), .map_ready(ready_s[1]),
    .map_pe(pe_o[1]), .map_spare(sp_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .fail(fail_o[1]), .spares_used(used_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input int d, input string tag);
    chk({tag, "_valid"}, 32'(valid_o[d]), 0);
    chk({tag, "_pe"},    32'(pe_o[d]),    0);
    chk({tag, "_spare"}, 32'(sp_o[d]),    0);
    chk({tag, "_busy"},  32'(busy_o[d]),  0);
    chk({tag, "_done"},  32'(done_o[d]),  0);
    chk({tag, "_fail"},  32'(fail_o[d]),  0);
    chk({tag, "_used"},  32'(used_o[d]),  0);
  endtask

  // Reference: faulty PEs and healthy spares are each listed in priority
  // order and zipped together; surplus faulty PEs mean failure.
  task automatic run_alloc(input int d, input logic [15:0] fm, input logic [3:0] sf,
                           input int rdy_pct, input bit noise);
    int  q_pe[$];
    int  q_sp[$];
    int  npairs, got, gap, idx;
    bit  exp_fail, fresh, fin;
    for (int k = 0; k < 16; k++) begin
      idx = (d == 1) ? 15 - k : k;
      if (fm[idx]) q_pe.push_back(idx);
    end
    for (int k = 0; k < 4; k++) begin
      idx = (d == 1) ? 3 - k : k;
      if (!sf[idx]) q_sp.push_back(idx);
    end
    npairs   = (q_pe.size() < q_sp.size()) ? q_pe.size() : q_sp.size();
    exp_fail = q_pe.size() > q_sp.size();

    @(negedge clk);
    fm_s[d] = fm; sf_s[d] = sf; start_s[d] = 1'b1; ready_s[d] = 1'b0;
    @(negedge clk);
    start_s[d] = 1'b0;
    if (noise) fm_s[d] = 16'($urandom);
    chk("accept_busy",  32'(busy_o[d]),  1);
    chk("accept_valid", 32'(valid_o[d]), 0);
    gap = 1; fresh = 1'b1; got = 0; fin = 1'b0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      @(negedge clk);
      gap++;
      ready_s[d] = 1'b0;
      start_s[d] = noise ? 1'($urandom_range(1)) : 1'b0;
      if (noise) fm_s[d] = 16'($urandom);
      if (valid_o[d]) begin
        if (fresh) chk("valid_latency", 32'(gap), 2);
        fresh = 1'b0;
        chk("pair_in_range", 32'(got < npairs), 1);
        if (got < npairs) begin
          chk("pair_pe",    32'(pe_o[d]), 32'(q_pe[got]));
          chk("pair_spare", 32'(sp_o[d]), 32'(q_sp[got]));
        end
        if ($urandom_range(99) < rdy_pct) begin
          ready_s[d] = 1'b1;
          got++;
          gap   = 0;
          fresh = 1'b1;
        end
      end else if (done_o[d] || fail_o[d]) begin
        start_s[d] = 1'b0;
        chk("end_latency", 32'(gap), 2);
        chk("end_done",    32'(done_o[d]), 32'(!exp_fail));
        chk("end_fail",    32'(fail_o[d]), 32'(exp_fail));
        chk("end_pairs",   32'(got), 32'(npairs));
        chk("end_used",    32'(used_o[d]), 32'(npairs));
        chk("end_busy",    32'(busy_o[d]), 1);
        fin = 1'b1;
      end else begin
        chk("no_stall", 32'(gap < 2), 1);
      end
    end
    if (!fin) chk("timeout", 0, 1);
    @(negedge clk);
    chk("idle_busy",  32'(busy_o[d]),  0);
    chk("idle_done",  32'(done_o[d]),  0);
    chk("idle_fail",  32'(fail_o[d]),  0);
    chk("idle_valid", 32'(valid_o[d]), 0);
    chk("idle_used",  32'(used_o[d]),  32'(npairs));
  endtask

  task automatic hold_and_reset();
    @(negedge clk);
    fm_s[0] = 16'h0012; sf_s[0] = 4'h1; start_s[0] = 1'b1; ready_s[0] = 1'b0;
    @(negedge clk);
    start_s[0] = 1'b0;
    @(negedge clk);
    chk("hold_first_valid", 32'(valid_o[0]), 1);
    chk("hold_first_pe",    32'(pe_o[0]),    1);
    chk("hold_first_spare", 32'(sp_o[0]),    1);
    for (int i = 0; i < 5; i++) begin
      start_s[0] = 1'b1;
      fm_s[0]    = 16'hFFFF;
      sf_s[0]    = 4'h0;
      @(negedge clk);
      chk("hold_valid", 32'(valid_o[0]), 1);
      chk("hold_pe",    32'(pe_o[0]),    1);
      chk("hold_spare", 32'(sp_o[0]),    1);
      chk("hold_used",  32'(used_o[0]),  0);
    end
    start_s[0] = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs(0, "async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs(0, "post_rst");
  endtask

  initial begin
    int d;
    logic [15:0] fm;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0; fm_s[i] = '0; sf_s[i] = '0; ready_s[i] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs(0, "reset_lsb");
    chk_reset_outputs(1, "reset_msb");
    rst_n = 1'b1;

    run_alloc(0, 16'h0000, 4'h0, 100, 1'b0);
    run_alloc(0, 16'h0012, 4'h1, 100, 1'b0);
    run_alloc(0, 16'h00F1, 4'h0, 100, 1'b0);
    run_alloc(1, 16'h8001, 4'h8, 100, 1'b0);
    run_alloc(0, 16'hFFFF, 4'hF, 100, 1'b0);
    hold_and_reset();
    run_alloc(0, 16'h0012, 4'h1, 100, 1'b0);

    repeat (30) begin
      d  = $urandom_range(1);
      fm = ($urandom_range(3) == 0) ? 16'h0000 : (16'($urandom) & 16'($urandom));
      run_alloc(d, fm, 4'($urandom), $urandom_range(100, 20), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
